// File: rtl/round_sequencer_pkg.sv
// Shared encodings for the hash round sequencer: opcodes, verify-stage decisions, FSM states.
package Definitions;

    typedef enum logic [1:0] {
        MD5     = 2'b00,
        SHA_1   = 2'b01,
        SHA_256 = 2'b10,
        OP_RSVD = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        WAIT     = 2'b00,
        CONTINUE = 2'b01,
        FINISH   = 2'b10
    } decision_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        DONE
    } seq_state_t;

    localparam logic [7:0] ROUND_IDLE = 8'hFF;
    // Highest round that may be issued is 126; CONTINUE at 127 is treated as an overrun.
    localparam logic [7:0] ROUND_LAST = 8'd127;

endpackage

// File: rtl/round_sequencer_if.sv
// Handshake bundle between the round sequencer, the round-verify stage and the hash core.
interface round_sequencer_if;
    import Definitions::*;

    logic       start;
    logic [1:0] opcode_in;
    logic       abort;
    logic [1:0] decision;
    logic       step_ready;
    logic       step_done;
    logic [7:0] round;
    logic [1:0] opcode;
    logic       step_valid;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  start, opcode_in, abort, decision, step_ready, step_done,
        output round, opcode, step_valid, busy, done, err
    );

    modport slave (
        output start, opcode_in, abort, decision, step_ready, step_done,
        input  round, opcode, step_valid, busy, done, err
    );

endinterface

// File: rtl/round_sequencer_watchdog.sv
// Per-round watchdog: counts enabled cycles and saturates at all-ones, flagging expiry.
module round_watchdog
    import Definitions::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + WIDTH'(1);
        end
    end

    assign expired = (count == '1);

endmodule

// File: rtl/round_sequencer.sv
// Hash round sequencer: issues rounds to the core until the verify stage answers FINISH.
// Defining ROUND_TIMEOUT_EN adds a per-round watchdog (round_watchdog) on the BUSY state.
module round_sequencer
    import Definitions::*;
#(
    parameter int unsigned TIMEOUT_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    round_sequencer_if.master bus
);

    seq_state_t state_q, state_d;
    logic [7:0] round_q, round_d;
    logic [1:0] opcode_q, opcode_d;
    logic       expired;
    logic       done_c;
    logic       err_c;

    if (TIMEOUT_W == 0) begin : g_cfg_check
        $error("round_sequencer: TIMEOUT_W must be at least 1");
    end

`ifdef ROUND_TIMEOUT_EN
    round_watchdog #(
        .WIDTH(TIMEOUT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != BUSY),
        .enable (state_q == BUSY),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            round_q  <= ROUND_IDLE;
            opcode_q <= MD5;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            opcode_q <= opcode_d;
        end
    end

    // Kept free of step_ready and abort so the core never sees a combinational loop.
    assign bus.step_valid = (state_q == ISSUE) && (bus.decision == CONTINUE)
                            && (round_q != ROUND_LAST);

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        opcode_d = opcode_q;
        done_c   = 1'b0;
        err_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    opcode_d = bus.opcode_in;
                    round_d  = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    round_d = ROUND_IDLE;
                end else if (bus.decision == FINISH) begin
                    state_d = DONE;
                end else if (bus.step_valid) begin
                    if (bus.step_ready) begin
                        state_d = BUSY;
                    end
                end else begin
                    err_c   = 1'b1;
                    state_d = IDLE;
                    round_d = ROUND_IDLE;
                end
            end
            BUSY: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    round_d = ROUND_IDLE;
                end else if (bus.step_done) begin
                    round_d = round_q + 8'd1;
                    state_d = ISSUE;
                end else if (expired) begin
                    err_c   = 1'b1;
                    state_d = IDLE;
                    round_d = ROUND_IDLE;
                end
            end
            DONE: begin
                done_c  = !bus.abort;
                state_d = IDLE;
                round_d = ROUND_IDLE;
            end
        endcase
    end

    assign bus.round  = round_q;
    assign bus.opcode = opcode_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_c;
    assign bus.err    = err_c;

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 8: width of the per-round watchdog counter (used only under ROUND_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a hash; sampled only in IDLE.
REQ-005 SHALL have port opcode_in  input  2  hash select (MD5, SHA_1, SHA_256, 2'b11), captured on accepted start.
REQ-006 SHALL have port abort  input  1  synchronous cancel of the current hash.
REQ-007 SHALL have port decision  input  2  WAIT/CONTINUE/FINISH from the round-verify stage, combinational from round/opcode.
REQ-008 SHALL have port step_ready  input  1  hash core can accept a round.
REQ-009 SHALL have port step_done  input  1  one-cycle pulse, core finished the accepted round.
REQ-010 SHALL have port round  output  8  current round number to the verify stage; 8'hFF when idle.
REQ-011 SHALL have port opcode  output  2  latched opcode to the verify stage and core.
REQ-012 SHALL have port step_valid  output  1  round issue request to the core.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse, hash complete.
REQ-015 SHALL have port err  output  1  one-cycle pulse, run terminated abnormally.

Function
REQ-016 SHALL implement states IDLE, ISSUE, BUSY, DONE.
REQ-017 IDLE: round = 8'hFF; start=1 -> opcode <= opcode_in, round <= 0, next ISSUE; start with abort=1 -> remain IDLE.
REQ-018 ISSUE, decision=FINISH -> DONE, no step issued.
REQ-019 ISSUE, decision=CONTINUE -> step_valid=1; step_valid&step_ready -> BUSY; step_ready=0 -> hold ISSUE, round and opcode stable.
REQ-020 ISSUE, decision=WAIT -> err pulse, next IDLE.
REQ-021 ISSUE, round=8'd127 and decision=CONTINUE -> err pulse, next IDLE, no step issued (no wrap into negative range).
REQ-022 BUSY: step_done=1 -> round <= round+1, next ISSUE; step_done outside BUSY SHALL be ignored.
REQ-023 DONE: done=1 for exactly that cycle, round <= 8'hFF, next IDLE.
REQ-024 abort=1 in any non-IDLE state -> next IDLE, round <= 8'hFF, no done, no err; abort has priority over step_done, decision and timeout.
REQ-025 start outside IDLE SHALL be ignored; opcode_in changes outside accepted start SHALL have no effect.
REQ-026 step_valid SHALL depend only on state and decision (no path from step_ready).
REQ-027 Latency: accepted start to first step_valid = 1 cycle; step_done to next step_valid = 1 cycle; FINISH in ISSUE to done = 1 cycle.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, round=8'hFF, opcode=MD5, step_valid=0, busy=0, done=0, err=0, watchdog cleared.
REQ-029 Reset asserted mid-run SHALL discard the run without done or err pulse.

Configuration
REQ-030 With ROUND_TIMEOUT_EN defined: watchdog counts cycles in BUSY, clears on entry to BUSY; reaching 2^TIMEOUT_W-1 without step_done -> err pulse, next IDLE, round <= 8'hFF.
REQ-031 Without ROUND_TIMEOUT_EN: no watchdog logic; BUSY waits indefinitely; TIMEOUT_W unused.

Structure
REQ-032 Opcode values (MD5, SHA_1, SHA_256) and decision values (WAIT, CONTINUE, FINISH) SHALL come from package Definitions; seq_state_t enum and constant ROUND_IDLE = 8'hFF SHALL be added there.
REQ-033 Watchdog SHALL be sub-module round_watchdog (inputs clk, rst_n, clear, enable; output expired), instantiated only under ROUND_TIMEOUT_EN.

Verification (bench pairs block with the round-verify stage)
REQ-034 rst_n=0 mid-run at round 3 -> next sample round=8'hFF, busy=0, step_valid=0, no done.
REQ-035 start, opcode_in=MD5, step_ready=1, step_done 1 cycle after each accept -> 4 accepts with round 0,1,2,3; done single pulse one cycle after round=4; round back to 8'hFF.
REQ-036 opcode_in=SHA_256, step_ready low 3 cycles on round 5 -> step_valid held, round=5 stable; 8 total accepts; done once.
REQ-037 SHA_1 run, abort with simultaneous step_done in BUSY at round 2 -> IDLE, round=8'hFF, no done, no err, round not incremented.
REQ-038 start pulse and opcode_in toggling during SHA_1 run -> ignored; opcode stays SHA_1, exactly 5 accepts.
REQ-039 ROUND_TIMEOUT_EN, TIMEOUT_W=4, step_done never -> err pulse 15 cycles after BUSY entry, then IDLE; without the macro busy stays 1.
